// File: rtl/crack_pkg.sv
// Shared types and defaults for the ARC4 cracker plaintext streamer.
// Contents: state_t FSM encoding, default bus widths, length-byte address,
// and the number of key header bytes emitted when the header option is built.
package crack_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_KEY_W  = 24;

    // The message length lives in the first word of pt memory.
    localparam logic [DEF_ADDR_W-1:0] LEN_ADDR = '0;

    // Key header is emitted MSB first, one byte per handshake.
    localparam int HDR_BYTES = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_LEN   = 3'd1,
        S_LAT_LEN  = 3'd2,
        S_HDR      = 3'd3,
        S_RD_BYTE  = 3'd4,
        S_LAT_BYTE = 3'd5,
        S_SEND     = 3'd6,
        S_FIN      = 3'd7
    } state_t;

endpackage

// File: rtl/pt_streamer.sv
// Purpose: read the length-prefixed plaintext out of the cracker pt memory and stream it.
// Latency: 3 cycles from accepted en to first read result; one byte per 3 cycles at best.
// Backpressure: out_data/out_valid are held stable until out_ready; no prefetch.
//
// Ports:
//   clk, rst (async, active-high)       single clock domain
//   en / rdy                            start request, accepted only in idle
//   key, key_valid                      cracker result, sampled on en && rdy
//   stop                                synchronous abort, beats every other input
//   pt_addr / pt_rddata                 sync-RAM read port (data one cycle after address)
//   out_data / out_valid / out_ready    byte stream with valid/ready handshake
//   done                                one-cycle completion pulse
//   found                               latched key_valid of the last accepted request
//
// Build option: PT_STREAMER_KEY_HEADER_EN -- when defined and found=1, the three key
// bytes (key[23:16], key[15:8], key[7:0]) precede the plaintext, even for len==0.
module pt_streamer
    import crack_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEY_W  = DEF_KEY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    input  logic              key_valid,
    input  logic              stop,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [DATA_W-1:0] pt_rddata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              found
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] idx;
    logic [KEY_W-1:0]  key_q;

`ifdef PT_STREAMER_KEY_HEADER_EN
    logic [1:0] hdr_cnt;

    // Select header byte n (0 = most significant) of the latched key.
    function automatic logic [DATA_W-1:0] hdr_byte(input logic [KEY_W-1:0] k,
                                                   input logic [1:0]       n);
        logic [KEY_W-1:0] s;
        s = k >> (DATA_W * (HDR_BYTES - 1 - int'(n)));
        return s[DATA_W-1:0];
    endfunction
`else
    // Key is still latched so the register set is identical in both builds.
    logic key_unused;
    assign key_unused = ^key_q;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (en) state_nxt = S_RD_LEN;
                S_RD_LEN:  state_nxt = S_LAT_LEN;
                S_LAT_LEN: begin
`ifdef PT_STREAMER_KEY_HEADER_EN
                    // Header goes out whenever the key was found, even for len==0.
                    state_nxt = found ? S_HDR : S_FIN;
`else
                    state_nxt = (!found || pt_rddata == '0) ? S_FIN : S_RD_BYTE;
`endif
                end
                S_HDR: begin
`ifdef PT_STREAMER_KEY_HEADER_EN
                    if (out_ready && hdr_cnt == 2'(HDR_BYTES - 1)) begin
                        state_nxt = (len == '0) ? S_FIN : S_RD_BYTE;
                    end
`else
                    state_nxt = S_IDLE;
`endif
                end
                S_RD_BYTE:  state_nxt = S_LAT_BYTE;
                S_LAT_BYTE: state_nxt = S_SEND;
                S_SEND: begin
                    // Equality, not >=, so len=255 finishes without idx wrapping.
                    if (out_ready) state_nxt = (idx == len) ? S_FIN : S_RD_BYTE;
                end
                S_FIN:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic (state-decoded)
    always_comb begin
        rdy     = (state == S_IDLE);
        done    = (state == S_FIN) && !stop;
        pt_addr = (state == S_RD_BYTE) ? idx : ADDR_W'(LEN_ADDR);
    end

    // Datapath and output holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            idx       <= '0;
            key_q     <= '0;
            found     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef PT_STREAMER_KEY_HEADER_EN
            hdr_cnt   <= '0;
`endif
        end else if (stop) begin
            // Abort drops any pending byte but keeps the last found status.
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        found <= key_valid;
                        key_q <= key;
                        idx   <= ADDR_W'(1);
                    end
                end
                S_LAT_LEN: begin
                    len <= ADDR_W'(pt_rddata);
`ifdef PT_STREAMER_KEY_HEADER_EN
                    if (found) begin
                        hdr_cnt   <= '0;
                        out_data  <= hdr_byte(key_q, 2'd0);
                        out_valid <= 1'b1;
                    end
`endif
                end
`ifdef PT_STREAMER_KEY_HEADER_EN
                S_HDR: begin
                    if (out_ready) begin
                        if (hdr_cnt == 2'(HDR_BYTES - 1)) begin
                            out_valid <= 1'b0;
                        end else begin
                            hdr_cnt  <= hdr_cnt + 2'd1;
                            out_data <= hdr_byte(key_q, hdr_cnt + 2'd1);
                        end
                    end
                end
`endif
                S_LAT_BYTE: begin
                    out_data  <= pt_rddata;
                    out_valid <= 1'b1;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx != len) idx <= idx + ADDR_W'(1);
                    end
                end
                S_FIN: out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pt_streamer.sv
// Self-checking bench for pt_streamer: table of stream scenarios plus hand-written
// abort / reset / en+stop sequences, all scored against a queue-based reference of
// the expected byte stream built straight from the memory image.
module tb_pt_streamer;

`ifdef PT_STREAMER_KEY_HEADER_EN
    localparam int HDRN = 3;
`else
    localparam int HDRN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        key_valid;
    logic        stop;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        found;

    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous-read pt memory
    always @(posedge clk) pt_rddata <= mem[pt_addr];

    pt_streamer #(.ADDR_W(8), .DATA_W(8), .KEY_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .key_valid (key_valid),
        .stop      (stop),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .found     (found)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Start one request and score the whole resulting stream.
    task automatic run_stream(input int len, input bit kv, input logic [23:0] k,
                              input int rdy_pct, input int exp_lat, input string tag);
        logic [7:0] expq[$];
        logic [7:0] got[$];
        int         cyc;
        bit         seen_done;
        bit         stalled;
        bit         any_valid;
        bit         stable_ok;
        logic [7:0] held;

        mem[0] = len[7:0];
        if (kv) begin
            if (HDRN != 0) begin
                expq.push_back(k[23:16]);
                expq.push_back(k[15:8]);
                expq.push_back(k[7:0]);
            end
            for (int i = 1; i <= len; i++) expq.push_back(mem[i]);
        end

        @(negedge clk);
        chk({tag, "_rdy_idle"}, 32'(rdy), 32'd1);
        key       = k;
        key_valid = kv;
        en        = 1'b1;

        seen_done = 0;
        stalled   = 0;
        any_valid = 0;
        stable_ok = 1;
        held      = '0;
        cyc       = 0;
        while (!seen_done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                // Scramble the request inputs: only the accepted values may matter.
                en        = 1'b0;
                key       = 24'($urandom);
                key_valid = 1'($urandom);
            end
            if (stalled && (out_valid !== 1'b1 || out_data !== held)) stable_ok = 0;
            out_ready = ($urandom_range(99) < rdy_pct);
            if (out_valid) any_valid = 1;
            if (out_valid && out_ready) got.push_back(out_data);
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (done) seen_done = 1;
        end

        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_found"}, 32'(found), 32'(kv));
        chk({tag, "_stable"}, 32'(stable_ok), 32'd1);
        if (!kv) chk({tag, "_no_valid"}, 32'(any_valid), 32'd0);
        if (exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            if (got[i] !== expq[i]) chk({tag, "_byte"}, 32'(got[i]), 32'(expq[i]));
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_rdy_after"}, 32'(rdy), 32'd1);
    endtask

    typedef struct {
        int          len;
        bit          kv;
        logic [23:0] key;
        int          rdy_pct;
        int          exp_lat;   // -1: not checked (random stalls)
        bit          rnd_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        int n;

        rst = 1'b1; en = 1'b0; key = '0; key_valid = 1'b0; stop = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset values
        #1;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_pt_addr", 32'(pt_addr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table of scenarios: latency = 3 + 3*len (+3 header) when out_ready stays high
        vecs[0] = '{3,   1'b1, 24'h1A2B3C, 100, 12 + HDRN,  1'b0};
        vecs[1] = '{5,   1'b0, 24'h00BEEF, 100, 3,          1'b1};
        vecs[2] = '{0,   1'b1, 24'h1A2B3C, 100, 3 + HDRN,   1'b1};
        vecs[3] = '{1,   1'b1, 24'hC0FFEE, 100, 6 + HDRN,   1'b1};
        vecs[4] = '{7,   1'b1, 24'h123456,  50, -1,         1'b1};
        vecs[5] = '{255, 1'b1, 24'hA5A5A5,  60, -1,         1'b1};
        vecs[6] = '{255, 1'b1, 24'h5A5A5A, 100, 768 + HDRN, 1'b1};
        vecs[7] = '{0,   1'b0, 24'h777777, 100, 3,          1'b1};

        mem[1] = 8'h48; mem[2] = 8'h69; mem[3] = 8'h21;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rnd_data)
                for (int i = 1; i < 256; i++) mem[i] = 8'($urandom);
            run_stream(vecs[v].len, vecs[v].kv, vecs[v].key, vecs[v].rdy_pct,
                       vecs[v].exp_lat, $sformatf("vec%0d", v));
        end

        // Randomised streams
        for (int r = 0; r < 6; r++) begin
            for (int i = 1; i < 256; i++) mem[i] = 8'($urandom);
            run_stream(int'($urandom_range(40)), 1'($urandom), 24'($urandom),
                       int'($urandom_range(30, 100)), -1, $sformatf("rnd%0d", r));
        end

        // Abort after the second byte, while the third is pending
        for (int i = 1; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'd10;
        @(negedge clk);
        key = 24'h010203; key_valid = 1'b1; en = 1'b1; out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 2; c++) begin
            @(negedge clk);
            en = 1'b0;
            if (out_valid) n++;
        end
        chk("stop_two_bytes", 32'(n), 32'd2);
        out_ready = 1'b0;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        chk("stop_third_pending", 32'(ok), 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_out_valid", 32'(out_valid), 32'd0);
        chk("stop_rdy", 32'(rdy), 32'd1);
        chk("stop_found_kept", 32'(found), 32'd1);
        ok = 1;
        for (int c = 0; c < 10; c++) begin
            if (done || out_valid) ok = 0;
            @(negedge clk);
        end
        chk("stop_no_done", 32'(ok), 32'd1);

        // en and stop together in idle: request dropped
        en = 1'b1; stop = 1'b1; key_valid = 1'b0;
        @(negedge clk);
        en = 1'b0; stop = 1'b0;
        chk("enstop_rdy", 32'(rdy), 32'd1);
        chk("enstop_found_kept", 32'(found), 32'd1);
        ok = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || !rdy) ok = 0;
        end
        chk("enstop_idle", 32'(ok), 32'd1);

        // Asynchronous reset while a byte is stalled in SEND
        mem[0] = 8'd20;
        key = 24'hDEAD01; key_valid = 1'b1; en = 1'b1; out_ready = 1'b0;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            en = 1'b0;
            if (out_valid) ok = 1;
        end
        chk("arst_reached_send", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_rdy", 32'(rdy), 32'd1);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_found", 32'(found), 32'd0);
        chk("arst_pt_addr", 32'(pt_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i < 256; i++) mem[i] = 8'($urandom);
        run_stream(4, 1'b1, 24'h0F1E2D, 100, 15 + HDRN, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
